// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit with MTHI/MTLO and cancel
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [WIDTH-1:0] LAST_ITER = WIDTH'(WIDTH - 1);

    state_t           state;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] mcand;

    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy_o = (state != IDLE);

    // Operand magnitudes, one iteration step and the final sign correction
    always_comb begin
        rs_neg    = ~op_i[0] & rs_i[WIDTH-1];
        rt_neg    = ~op_i[0] & rt_i[WIDTH-1];
        rs_mag    = rs_neg ? -rs_i : rs_i;
        rt_mag    = rt_neg ? -rt_i : rt_i;
        add_sum   = {1'b0, acc} + (lo_reg[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        rem_shift = {acc, lo_reg[WIDTH-1]};
        diff      = rem_shift - {1'b0, mcand};
        prod      = {acc, lo_reg};
        prod_fix  = neg_lo ? -prod : prod;
        quo_fix   = neg_lo ? -lo_reg : lo_reg;
        rem_fix   = neg_hi ? -acc : acc;
    end

    // Control FSM, iterative datapath and architectural HI/LO registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state  <= IDLE;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            lo_reg <= '0;
            mcand  <= '0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div <= op_i[1];
                                cnt    <= '0;
                                if (op_i[1] && (rt_i == '0)) begin
                                    // divide by zero: preset the result and skip iteration
                                    acc    <= rs_i;
                                    lo_reg <= '1;
                                    mcand  <= '0;
                                    neg_lo <= 1'b0;
                                    neg_hi <= 1'b0;
                                    state  <= FINISH;
                                end else begin
                                    acc    <= '0;
                                    neg_lo <= rs_neg ^ rt_neg;
                                    neg_hi <= op_i[1] ? rs_neg : (rs_neg ^ rt_neg);
                                    mcand  <= op_i[1] ? rt_mag : rs_mag;
                                    lo_reg <= op_i[1] ? rs_mag : rt_mag;
                                    state  <= CALC;
                                end
                            end
                            OP_MTHI: hi_o <= rs_i;
                            OP_MTLO: lo_o <= rs_i;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            acc    <= diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
                            lo_reg <= {lo_reg[WIDTH-2:0], ~diff[WIDTH]};
                        end else begin
                            acc    <= add_sum[WIDTH:1];
                            lo_reg <= {add_sum[0], lo_reg[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    if (!cancel_i) begin
                        done_o <= 1'b1;
                        if (is_div) begin
                            hi_o <= rem_fix;
                            lo_o <= quo_fix;
                        end else begin
                            hi_o <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_o <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are even and 4 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n_i, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: operation request, sampled at the clk edge.
REQ-005 The block SHALL have port op_i, input, 3 bits, with this encoding:
- 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO;
- 6 and 7 are no-ops.
REQ-006 The block SHALL have port rs_i, input, WIDTH bits: first operand (dividend / multiplicand / MTHI-MTLO source).
REQ-007 The block SHALL have port rt_i, input, WIDTH bits: second operand (divisor / multiplier).
REQ-008 The block SHALL have port cancel_i, input, 1 bit: abort of the in-flight operation (pipeline flush).
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while an operation is in flight.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when HI/LO hold a new MULT/DIV result.
REQ-011 The block SHALL have ports hi_o and lo_o, outputs, WIDTH bits each: architectural HI and LO registers.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and FINISH; busy_o is high in CALC and FINISH only.
REQ-013 In IDLE, start_i=1 with op 0-3 SHALL latch the operands and go to CALC at edge E0.
- Exception: divide by zero (REQ-019) goes directly to FINISH.
REQ-014 In IDLE, start_i=1 with op 4 or 5 SHALL write rs_i into HI or LO at E0.
- State stays IDLE; busy_o and done_o are not asserted.
REQ-015 start_i SHALL be ignored while busy_o=1; op 6-7 SHALL have no effect.
REQ-016 CALC SHALL last exactly WIDTH cycles, one bit per cycle:
- shift-add for multiply, restoring shift-subtract for divide;
- both run on operand magnitudes, using a WIDTH-bit iteration counter.
REQ-017 FINISH SHALL apply sign correction and write HI/LO at edge E(WIDTH+1).
- done_o=1 and busy_o=0 in the cycle following that edge.
- A new start_i SHALL be accepted in that done_o cycle.
REQ-018 Arithmetic rules:
- MULT and MULTU SHALL give the 2*WIDTH-bit signed or unsigned product, with HI = upper half and LO = lower half.
- DIV and DIVU SHALL give LO = quotient truncated toward zero and HI = remainder, the remainder taking the sign of the dividend.
REQ-019 Divide by zero (rt_i=0, DIV or DIVU) SHALL skip CALC:
- LO = all ones and HI = rs_i, written at E1;
- done_o is high in the cycle after E1.
REQ-020 DIV of the most-negative value by -1 SHALL give LO = most-negative value and HI = 0, with no error indication.
REQ-021 When cancel_i=1 in CALC or FINISH:
- the FSM SHALL return to IDLE at the next edge without writing HI/LO or asserting done_o;
- cancel_i takes priority over FINISH completion.
REQ-022 cancel_i in IDLE SHALL be ignored, and SHALL NOT block a simultaneous start_i.
REQ-023 hi_o and lo_o SHALL change only on MTHI/MTLO, FINISH, or reset; operands are not sampled after E0.

Reset
REQ-024 When reset_n_i=0, the block SHALL immediately, without waiting for a clk edge:
- set state to IDLE;
- clear hi_o, lo_o and the internal datapath registers to 0;
- drive busy_o and done_o to 0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation; no done_o pulse follows reset release.
REQ-026 The first start_i SHALL be accepted on the first rising edge with reset_n_i=1.

Verification (WIDTH=32)
REQ-027 MULT on 0xFFFFFFFE and 0x00000003 SHALL give:
- done_o exactly 33 cycles after acceptance;
- HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-028 MULTU on 0xFFFFFFFF and 0xFFFFFFFF SHALL give HI=0xFFFFFFFE, LO=0x00000001.
REQ-029 DIV on 0xFFFFFFF9 (-7) and 2 SHALL give LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- DIVU on 7 and 2 SHALL give LO=3 and HI=1.
REQ-030 DIV on 0x80000000 and 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
- DIVU on 0x1234 and 0 SHALL give done_o 1 cycle after acceptance, with LO=0xFFFFFFFF and HI=0x1234.
REQ-031 With HI/LO preloaded to 0xA5A5A5A5 by MTHI/MTLO:
- start a MULT;
- pulse start_i at CALC cycle 5: it SHALL be ignored;
- pulse cancel_i at CALC cycle 10: busy_o SHALL be 0 next cycle, no done_o, HI/LO unchanged.
REQ-032 reset_n_i low mid-DIV SHALL give busy_o=0 and hi_o=lo_o=0 before the next clk edge; no done_o after release.
